dir_reg_write_ctrl: RTL and testbench
=====================================

Name: dir_reg_write_ctrl

Overview:
- Sequencing controller for the port register bank and its direction-register strobe decoder.
- Shares the single register-write path between two requesters: a host write port and an autoload sequencer.
- The autoload sequencer initialises all 4 direction registers from an init vector.
- Drives the address, strobe, bank-select and write data consumed by the direction decoder and the data-register decoder.

Parameters:
DATA_W, 8, width of one register write word
GAP_CYCLES, 1, forced idle cycles after every strobe (0..15; 0 allows back-to-back strobes)

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  synchronous, active-high reset
host_req  in  1  host write request, held until host_ack
host_addr  in  2  host target register index 0..3
host_sel_dir  in  1  1 = direction bank, 0 = data bank
host_data  in  DATA_W  host write data
host_ack  out  1  one-cycle pulse, coincident with the host strobe
init_start  in  1  pulse: request autoload of the 4 direction registers
init_values  in  4*DATA_W  init word for reg i at bits [i*DATA_W +: DATA_W]
init_busy  out  1  autoload pending or in progress
init_done  out  1  one-cycle pulse after the last autoload strobe and its gap
reg_addr  out  2  register index to decoder
reg_strob  out  1  one-cycle write strobe
reg_choose_dir  out  1  bank select to decoder
reg_wdata  out  DATA_W  write data to register bank

Behaviour:
- Reset: all outputs 0; state IDLE; gap counter, init index and init_pend cleared. Reset mid-operation aborts immediately: no further strobes, pending init discarded, no init_done.
- States: IDLE, HOST_WR, INIT_WR, GAP.
- IDLE, priority order:
  - init_pend or init_start: capture init_values into an internal shadow (only if not already captured while pending); set index 0; go to INIT_WR.
  - else host_req: register host_addr, host_sel_dir and host_data; go to HOST_WR.
  - else stay in IDLE.
- HOST_WR (1 cycle): reg_strob=1, host_ack=1, outputs = registered host fields. Latency: req sampled at edge N gives strobe in cycle N+1. Go to GAP, or IDLE if GAP_CYCLES=0.
- INIT_WR (1 cycle): reg_strob=1, reg_choose_dir=1, reg_addr=index, reg_wdata=shadow[index]. Go to GAP, or directly to the next INIT_WR/finish if GAP_CYCLES=0.
- GAP: lasts exactly GAP_CYCLES cycles with reg_strob=0. On exit:
  - during autoload with index<3: index+1, go to INIT_WR;
  - during autoload with index=3: init_done=1 for that exit cycle, go to IDLE;
  - host write: go to IDLE.
- reg_addr, reg_choose_dir and reg_wdata hold their last values when reg_strob=0. Only reg_strob and host_ack are qualifying.
- init_busy: set the cycle after init_start is accepted or latched pending; cleared on the cycle after init_done.
- init_start arrives while HOST_WR/GAP of a host write: set init_pend and capture init_values then; autoload is served before any further host request.
- init_start arrives during an autoload: ignored; the shadow is not overwritten.
- Simultaneous init_start and host_req in IDLE: autoload wins. Host waits, req held; served after init_done.
- Host still asserting req after ack: treated as a new request once back in IDLE. The host must deassert req in the ack cycle to write once.
- Autoload total length: 4 strobes + 4×GAP_CYCLES cycles.

Test Plan:
- Reset, then host_req with addr=2, sel_dir=1, data=0xA5 held at edge N → cycle N+1: reg_strob=1, host_ack=1, reg_addr=2, reg_choose_dir=1, reg_wdata=0xA5; strobe low in N+2; second request not accepted before N+3 (GAP=1).
- init_start with init_values={0x44,0x33,0x22,0x11} → strobes at addr 0,1,2,3 with data 0x11,0x22,0x33,0x44, every other cycle, choose_dir=1; init_done pulse 1 cycle after the last strobe; init_busy high throughout.
- init_start and host_req (addr 1, 0x5A) asserted the same cycle in IDLE → 4 autoload strobes first, then host strobe with host_ack after init_done; exactly 5 strobes total.
- init_start during a host write's GAP, with init_values changed the next cycle → autoload uses the captured values; the later change has no effect.
- rst asserted between the 2nd and 3rd autoload strobes → next cycle all outputs 0; no further strobes; no init_done; a fresh init_start restarts from addr 0.
- GAP_CYCLES=0 build: autoload produces 4 consecutive strobe cycles; init_done in the cycle after the 4th strobe.

Source files
------------

// File: rtl/dir_reg_write_ctrl.sv
// rtl/dir_reg_write_ctrl.sv - write-path sequencer shared by host port and direction autoload
//
// Ports:
//   clk, rst                 rising-edge clock, synchronous active-high reset
//   host_req/addr/sel_dir/data, host_ack
//                            host write port; request held until the ack pulse
//   init_start, init_values  autoload request and the four direction init words
//   init_busy, init_done     autoload pending/in progress, completion pulse
//   reg_addr, reg_strob, reg_choose_dir, reg_wdata
//                            single write path into the register bank decoders

module dir_reg_write_ctrl #(
   parameter int DATA_W     = 8,
   parameter int GAP_CYCLES = 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  host_req,
   input  logic [1:0]            host_addr,
   input  logic                  host_sel_dir,
   input  logic [DATA_W-1:0]     host_data,
   output logic                  host_ack,
   input  logic                  init_start,
   input  logic [4*DATA_W-1:0]   init_values,
   output logic                  init_busy,
   output logic                  init_done,
   output logic [1:0]            reg_addr,
   output logic                  reg_strob,
   output logic                  reg_choose_dir,
   output logic [DATA_W-1:0]     reg_wdata
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      HOST_WR = 2'd1,
      INIT_WR = 2'd2,
      GAP     = 2'd3
   } state_t;

   localparam bit         HAS_GAP  = (GAP_CYCLES > 0);
   localparam logic [3:0] GAP_LAST = (GAP_CYCLES > 0) ? 4'(GAP_CYCLES - 1) : 4'd0;

   state_t                state_q, state_d;
   logic [3:0]            gap_cnt_q, gap_cnt_d;
   logic [1:0]            idx_q, idx_d;
   logic                  init_pend_q, init_pend_d;
   logic                  init_mode_q, init_mode_d;
   logic                  init_busy_q, init_busy_d;
   logic                  done_q, done_d;
   logic [4*DATA_W-1:0]   shadow_q, shadow_d;
   logic [1:0]            reg_addr_q, reg_addr_d;
   logic                  reg_dir_q, reg_dir_d;
   logic [DATA_W-1:0]     reg_wdata_q, reg_wdata_d;

   logic [1:0]            idx_nxt;
   logic                  gap_last;

   assign idx_nxt  = idx_q + 2'd1;
   assign gap_last = (state_q == GAP) && (gap_cnt_q == GAP_LAST);

   // With a gap the completion pulse coincides with the final gap cycle;
   // without one it comes from done_q in the IDLE cycle after the 4th strobe.
   assign init_done      = (gap_last && init_mode_q && (idx_q == 2'd3)) || done_q;
   assign reg_strob      = (state_q == HOST_WR) || (state_q == INIT_WR);
   assign host_ack       = (state_q == HOST_WR);
   assign init_busy      = init_busy_q;
   assign reg_addr       = reg_addr_q;
   assign reg_choose_dir = reg_dir_q;
   assign reg_wdata      = reg_wdata_q;

   always_comb begin
      state_d     = state_q;
      gap_cnt_d   = gap_cnt_q;
      idx_d       = idx_q;
      init_pend_d = init_pend_q;
      init_mode_d = init_mode_q;
      init_busy_d = init_busy_q;
      done_d      = 1'b0;
      shadow_d    = shadow_q;
      reg_addr_d  = reg_addr_q;
      reg_dir_d   = reg_dir_q;
      reg_wdata_d = reg_wdata_q;

      if (init_done) begin
         init_busy_d = 1'b0;
      end

      // An autoload request during a host write is parked with its values
      // frozen now, so later changes on init_values cannot leak in.
      if (init_start && !init_pend_q &&
          ((state_q == HOST_WR) || ((state_q == GAP) && !init_mode_q))) begin
         init_pend_d = 1'b1;
         shadow_d    = init_values;
         init_busy_d = 1'b1;
      end

      unique case (state_q)
         IDLE: begin
            if (init_pend_q || init_start) begin
               if (!init_pend_q) begin
                  shadow_d = init_values;
               end
               idx_d       = 2'd0;
               init_mode_d = 1'b1;
               init_pend_d = 1'b0;
               init_busy_d = 1'b1;
               reg_addr_d  = 2'd0;
               reg_dir_d   = 1'b1;
               reg_wdata_d = init_pend_q ? shadow_q[DATA_W-1:0] : init_values[DATA_W-1:0];
               state_d     = INIT_WR;
            end else if (host_req) begin
               reg_addr_d  = host_addr;
               reg_dir_d   = host_sel_dir;
               reg_wdata_d = host_data;
               state_d     = HOST_WR;
            end
         end

         HOST_WR: begin
            gap_cnt_d = 4'd0;
            state_d   = HAS_GAP ? GAP : IDLE;
         end

         INIT_WR: begin
            gap_cnt_d = 4'd0;
            if (HAS_GAP) begin
               state_d = GAP;
            end else if (idx_q != 2'd3) begin
               idx_d       = idx_nxt;
               reg_addr_d  = idx_nxt;
               reg_wdata_d = shadow_q[int'(idx_nxt)*DATA_W +: DATA_W];
               state_d     = INIT_WR;
            end else begin
               init_mode_d = 1'b0;
               done_d      = 1'b1;
               state_d     = IDLE;
            end
         end

         GAP: begin
            if (gap_cnt_q == GAP_LAST) begin
               if (init_mode_q && (idx_q != 2'd3)) begin
                  idx_d       = idx_nxt;
                  reg_addr_d  = idx_nxt;
                  reg_wdata_d = shadow_q[int'(idx_nxt)*DATA_W +: DATA_W];
                  state_d     = INIT_WR;
               end else begin
                  init_mode_d = 1'b0;
                  state_d     = IDLE;
               end
            end else begin
               gap_cnt_d = gap_cnt_q + 4'd1;
            end
         end

         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         gap_cnt_q   <= 4'd0;
         idx_q       <= 2'd0;
         init_pend_q <= 1'b0;
         init_mode_q <= 1'b0;
         init_busy_q <= 1'b0;
         done_q      <= 1'b0;
         shadow_q    <= '0;
         reg_addr_q  <= 2'd0;
         reg_dir_q   <= 1'b0;
         reg_wdata_q <= '0;
      end else begin
         state_q     <= state_d;
         gap_cnt_q   <= gap_cnt_d;
         idx_q       <= idx_d;
         init_pend_q <= init_pend_d;
         init_mode_q <= init_mode_d;
         init_busy_q <= init_busy_d;
         done_q      <= done_d;
         shadow_q    <= shadow_d;
         reg_addr_q  <= reg_addr_d;
         reg_dir_q   <= reg_dir_d;
         reg_wdata_q <= reg_wdata_d;
      end
   end

endmodule

// File: tb/tb_dir_reg_write_ctrl.sv
// tb/tb_dir_reg_write_ctrl.sv - directed bench for dir_reg_write_ctrl (GAP_CYCLES=1 and 0)

module tb_dir_reg_write_ctrl;

   logic        clk;
   logic        rst;

   logic        host_req;
   logic [1:0]  host_addr;
   logic        host_sel_dir;
   logic [7:0]  host_data;
   logic        host_ack;
   logic        init_start;
   logic [31:0] init_values;
   logic        init_busy;
   logic        init_done;
   logic [1:0]  reg_addr;
   logic        reg_strob;
   logic        reg_choose_dir;
   logic [7:0]  reg_wdata;

   logic        z_host_req;
   logic [1:0]  z_host_addr;
   logic        z_host_sel_dir;
   logic [7:0]  z_host_data;
   logic        z_host_ack;
   logic        z_init_start;
   logic [31:0] z_init_values;
   logic        z_init_busy;
   logic        z_init_done;
   logic [1:0]  z_reg_addr;
   logic        z_reg_strob;
   logic        z_reg_choose_dir;
   logic [7:0]  z_reg_wdata;

   int n_checks = 0;
   int n_pass   = 0;
   int strobe_cnt = 0;
   int cnt0;

   dir_reg_write_ctrl #(.DATA_W(8), .GAP_CYCLES(1)) dut (
      .clk(clk), .rst(rst),
      .host_req(host_req), .host_addr(host_addr), .host_sel_dir(host_sel_dir),
      .host_data(host_data), .host_ack(host_ack),
      .init_start(init_start), .init_values(init_values),
      .init_busy(init_busy), .init_done(init_done),
      .reg_addr(reg_addr), .reg_strob(reg_strob),
      .reg_choose_dir(reg_choose_dir), .reg_wdata(reg_wdata)
   );

   dir_reg_write_ctrl #(.DATA_W(8), .GAP_CYCLES(0)) dut_g0 (
      .clk(clk), .rst(rst),
      .host_req(z_host_req), .host_addr(z_host_addr), .host_sel_dir(z_host_sel_dir),
      .host_data(z_host_data), .host_ack(z_host_ack),
      .init_start(z_init_start), .init_values(z_init_values),
      .init_busy(z_init_busy), .init_done(z_init_done),
      .reg_addr(z_reg_addr), .reg_strob(z_reg_strob),
      .reg_choose_dir(z_reg_choose_dir), .reg_wdata(z_reg_wdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (reg_strob) strobe_cnt++;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end else begin
         n_pass++;
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Entered in the first autoload strobe cycle; leaves in the IDLE cycle after init_done.
   task automatic run_autoload(input string tag, input logic [31:0] vals);
      for (int i = 0; i < 4; i++) begin
         check({tag, "_strob"}, reg_strob, 1'b1);
         check({tag, "_addr"},  reg_addr, i);
         check({tag, "_wdata"}, reg_wdata, (vals >> (8*i)) & 32'hFF);
         check({tag, "_dir"},   reg_choose_dir, 1'b1);
         check({tag, "_ack"},   host_ack, 1'b0);
         check({tag, "_busy"},  init_busy, 1'b1);
         step();
         check({tag, "_gap_strob"}, reg_strob, 1'b0);
         check({tag, "_gap_done"},  init_done, (i == 3) ? 1'b1 : 1'b0);
         check({tag, "_gap_busy"},  init_busy, 1'b1);
         step();
      end
      check({tag, "_end_done"}, init_done, 1'b0);
      check({tag, "_end_busy"}, init_busy, 1'b0);
   endtask

   initial begin
      rst = 1'b1;
      host_req = 1'b0; host_addr = 2'd0; host_sel_dir = 1'b0; host_data = 8'h00;
      init_start = 1'b0; init_values = 32'h0;
      z_host_req = 1'b0; z_host_addr = 2'd0; z_host_sel_dir = 1'b0; z_host_data = 8'h00;
      z_init_start = 1'b0; z_init_values = 32'h0;
      step();
      step();
      check("rst_strob", reg_strob, 1'b0);
      check("rst_ack",   host_ack, 1'b0);
      check("rst_addr",  reg_addr, 2'd0);
      check("rst_dir",   reg_choose_dir, 1'b0);
      check("rst_wdata", reg_wdata, 8'h00);
      check("rst_busy",  init_busy, 1'b0);
      check("rst_done",  init_done, 1'b0);

      // Host write, request held past the ack to probe the gap spacing
      rst = 1'b0;
      host_req = 1'b1; host_addr = 2'd2; host_sel_dir = 1'b1; host_data = 8'hA5;
      step();
      check("h1_strob", reg_strob, 1'b1);
      check("h1_ack",   host_ack, 1'b1);
      check("h1_addr",  reg_addr, 2'd2);
      check("h1_dir",   reg_choose_dir, 1'b1);
      check("h1_wdata", reg_wdata, 8'hA5);
      host_addr = 2'd1; host_sel_dir = 1'b0; host_data = 8'h3C;
      step();
      check("h1_gap_strob", reg_strob, 1'b0);
      check("h1_hold_addr", reg_addr, 2'd2);
      check("h1_hold_data", reg_wdata, 8'hA5);
      step();
      check("h2_idle_strob", reg_strob, 1'b0);
      step();
      check("h2_strob", reg_strob, 1'b1);
      check("h2_ack",   host_ack, 1'b1);
      check("h2_addr",  reg_addr, 2'd1);
      check("h2_dir",   reg_choose_dir, 1'b0);
      check("h2_wdata", reg_wdata, 8'h3C);
      host_req = 1'b0;
      step();
      step();

      // Plain autoload
      init_start = 1'b1; init_values = 32'h44332211;
      step();
      init_start = 1'b0;
      run_autoload("al1", 32'h44332211);

      // Simultaneous init_start and host_req: autoload first
      cnt0 = strobe_cnt;
      init_start = 1'b1; init_values = 32'h0D0C0B0A;
      host_req = 1'b1; host_addr = 2'd1; host_sel_dir = 1'b0; host_data = 8'h5A;
      step();
      init_start = 1'b0;
      run_autoload("al2", 32'h0D0C0B0A);
      check("sim_idle_strob", reg_strob, 1'b0);
      step();
      check("sim_h_strob", reg_strob, 1'b1);
      check("sim_h_ack",   host_ack, 1'b1);
      check("sim_h_addr",  reg_addr, 2'd1);
      check("sim_h_wdata", reg_wdata, 8'h5A);
      check("sim_h_dir",   reg_choose_dir, 1'b0);
      host_req = 1'b0;
      step();
      step();
      check("sim_strobe_count", strobe_cnt - cnt0, 5);

      // init_start during a host write gap; values change afterwards
      host_req = 1'b1; host_addr = 2'd3; host_sel_dir = 1'b1; host_data = 8'h77;
      step();
      check("h3_strob", reg_strob, 1'b1);
      check("h3_wdata", reg_wdata, 8'h77);
      host_req = 1'b0;
      step();
      init_start = 1'b1; init_values = 32'h84838281;
      step();
      init_start = 1'b0; init_values = 32'hFFFFFFFF;
      check("pend_busy",  init_busy, 1'b1);
      check("pend_strob", reg_strob, 1'b0);
      step();
      run_autoload("al3", 32'h84838281);

      // Reset between the 2nd and 3rd autoload strobes
      init_start = 1'b1; init_values = 32'hC4C3C2C1;
      step();
      init_start = 1'b0;
      check("ab_s0_addr", reg_addr, 2'd0);
      step();
      step();
      check("ab_s1_strob", reg_strob, 1'b1);
      check("ab_s1_addr",  reg_addr, 2'd1);
      step();
      rst = 1'b1;
      step();
      check("ab_strob", reg_strob, 1'b0);
      check("ab_ack",   host_ack, 1'b0);
      check("ab_addr",  reg_addr, 2'd0);
      check("ab_dir",   reg_choose_dir, 1'b0);
      check("ab_wdata", reg_wdata, 8'h00);
      check("ab_busy",  init_busy, 1'b0);
      check("ab_done",  init_done, 1'b0);
      rst = 1'b0;
      for (int i = 0; i < 6; i++) begin
         step();
         check("ab_quiet_strob", reg_strob, 1'b0);
         check("ab_quiet_done",  init_done, 1'b0);
      end
      init_start = 1'b1; init_values = 32'hD4D3D2D1;
      step();
      init_start = 1'b0;
      run_autoload("al4", 32'hD4D3D2D1);

      // GAP_CYCLES=0 build: back-to-back autoload strobes
      z_init_start = 1'b1; z_init_values = 32'h1D1C1B1A;
      step();
      z_init_start = 1'b0;
      for (int i = 0; i < 4; i++) begin
         check("g0_strob", z_reg_strob, 1'b1);
         check("g0_addr",  z_reg_addr, i);
         check("g0_wdata", z_reg_wdata, (32'h1D1C1B1A >> (8*i)) & 32'hFF);
         check("g0_dir",   z_reg_choose_dir, 1'b1);
         check("g0_done",  z_init_done, 1'b0);
         step();
      end
      check("g0_end_strob", z_reg_strob, 1'b0);
      check("g0_end_done",  z_init_done, 1'b1);
      check("g0_end_busy",  z_init_busy, 1'b1);
      step();
      check("g0_post_done", z_init_done, 1'b0);
      check("g0_post_busy", z_init_busy, 1'b0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
